// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_mul_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/adder_substractor.sv
// WIDTH-bit adder/subtractor stage with carry-out and N/Z/V flags.
module adder_substractor #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUBS,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             N,
    output logic             Z,
    output logic             V
);

    logic [WIDTH-1:0] b_eff;

    // Subtraction is A + ~B + 1; Cout then means "no borrow".
    assign b_eff     = B ^ {WIDTH{SUBS}};
    assign {Cout, S} = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, SUBS};
    assign N         = S[WIDTH-1];
    assign Z         = (S == '0);
    assign V         = (A[WIDTH-1] == b_eff[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier built around adder_substractor.
// Optional SEQ_MUL_ZERO_SKIP_EN: zero operands bypass RUN and finish in one cycle.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               Z,
    output logic               V
);

    localparam int CW = cnt_width(WIDTH);

    seq_mul_state_t   state, state_next;
    logic [WIDTH-1:0] mcand, hi, lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addend, sum;
    logic             cout;
    logic             flag_n, flag_z, flag_v;
    logic             unused_flags;
    logic             zero_op;
    logic             last_step;

    assign addend    = lo[0] ? mcand : '0;
    assign last_step = (cnt == CW'(WIDTH - 1));

    adder_substractor #(.WIDTH(WIDTH)) u_adder (
        .A    (hi),
        .B    (addend),
        .SUBS (1'b0),
        .S    (sum),
        .Cout (cout),
        .N    (flag_n),
        .Z    (flag_z),
        .V    (flag_v)
    );

    assign unused_flags = flag_n ^ flag_z ^ flag_v;

`ifdef SEQ_MUL_ZERO_SKIP_EN
    assign zero_op = (A == '0) || (B == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Handshake: a transfer happens on any rising edge where valid && ready.
    // in_ready/out_valid are pure decodes of the state register.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = zero_op ? DONE : RUN;
            end
            RUN: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= A;
                        hi    <= '0;
                        lo    <= zero_op ? '0 : B;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // Carry-out lands in the MSB of hi; dropping it breaks large products.
                    {hi, lo} <= {cout, sum, lo[WIDTH-1:1]};
                    if (!last_step) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign P = {hi, lo};
    assign Z = (P == '0);
    assign V = (hi != '0);

endmodule
